muldiv_scheduler: RTL

//  Issue/interlock controller for the iterative multiply/divide unit and the HI/LO registers.

---
 rtl/muldiv_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/muldiv_scheduler.sv
// Issue/interlock controller for the iterative multiply/divide unit and HI/LO.
// Starts the unit, counts its fixed latency, and stalls ID while HI/LO is pending.
module muldiv_scheduler #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       md_req_id,
  input  logic [1:0] md_op_id,
  input  logic       hilo_rd_id,
  input  logic       hilo_wr_id,
  input  logic       stall_in,
  input  logic       flush_ex,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_busy,
  output logic       md_done,
  output logic       hilo_we,
  output logic       stall_md
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_op;
  logic [1:0]       w_op_next;
  logic             r_start;
  logic             w_issue;
  logic             w_busy;
  logic             w_last;

  assign w_busy = (r_state == ST_BUSY);
  assign w_last = w_busy && (r_cnt == CNT_ONE);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (md_req_id && !stall_in && !flush_ex && !stall_md) begin
          w_issue      = 1'b1;
          w_state_next = ST_BUSY;
          w_op_next    = md_op_id;
          w_cnt_next   = md_op_id[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_BUSY: begin
        // cnt==0 cannot occur while busy; treat it as final so the FSM can never lock up
        if (r_cnt <= CNT_ONE) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_start <= w_issue;
    end
  end

  // Outputs are forced low while rst is high so an abort never leaks a done pulse
  assign md_start = r_start && !rst;
  assign md_op    = rst ? 2'b00 : r_op;
  assign md_busy  = w_busy && !rst;
  assign md_done  = w_last && !rst;
  assign hilo_we  = md_done;
  assign stall_md = w_busy && !rst && (md_req_id || hilo_rd_id || hilo_wr_id);

endmodule
